// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: FSM states, segment patterns,
// digit positions and the double-dabble iteration count. Honours ALU_DISP_SIGNED_EN.
package alu_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Segment patterns, bit order gfedcba, active-high.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;
    localparam logic [1:0] DIG_SIGN = 2'd3;

`ifdef ALU_DISP_SIGNED_EN
    localparam logic [1:0] DIG_LAST = DIG_SIGN;
    localparam logic [3:0] DIGIT_SEL_MASK = 4'b1111;
`else
    localparam logic [1:0] DIG_LAST = DIG_HUND;
    localparam logic [3:0] DIGIT_SEL_MASK = 4'b0111;
`endif

    localparam int ITER_COUNT = 8;
    localparam int ITER_W     = $clog2(ITER_COUNT);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_COUNT - 1);

    // Double-dabble correction applied to each BCD nibble before the shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit plus blank flag to common-cathode 7-segment pattern (gfedcba, active-high).
module seg7_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default first so every path assigns seg and no latch is inferred.
        seg = SEG_BLANK;
        if (!blank) begin
            for (int d = 0; d < 10; d++) begin
                if (bcd == 4'(d)) seg = SEG_DIGIT[d];
            end
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// ALU result to BCD (sequential double-dabble) and multiplexed 7-segment scan with
// leading-zero blanking. Define ALU_DISP_SIGNED_EN for two's-complement input and a sign digit.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [7:0] res_data,
    output logic       res_ready,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] digit_sel
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t              state;
    logic [7:0]          bin;
    logic [11:0]         bcd;
    logic [ITER_W-1:0]   iter;
    logic                pend_neg;

    logic [3:0]          disp_hund;
    logic [3:0]          disp_tens;
    logic [3:0]          disp_ones;
    logic                disp_neg;

    logic [CNT_W-1:0]    refresh_cnt;
    logic [1:0]          scan_idx;

    logic [7:0]          cap_mag;
    logic                cap_neg;
    logic [11:0]         bcd_adj;
    logic [11:0]         bcd_next;
    logic [7:0]          bin_next;

`ifdef ALU_DISP_SIGNED_EN
    // -128 negates to 8'h80, which still reads correctly as magnitude 128.
    assign cap_neg = res_data[7];
    assign cap_mag = res_data[7] ? 8'(-res_data) : res_data;
`else
    assign cap_neg = 1'b0;
    assign cap_mag = res_data;
`endif

    assign bcd_adj  = {dd_adjust(bcd[11:8]), dd_adjust(bcd[7:4]), dd_adjust(bcd[3:0])};
    assign bcd_next = {bcd_adj[10:0], bin[7]};
    assign bin_next = {bin[6:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            iter      <= '0;
            pend_neg  <= 1'b0;
            res_ready <= 1'b1;
            busy      <= 1'b0;
            disp_hund <= '0;
            disp_tens <= '0;
            disp_ones <= '0;
            disp_neg  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (res_valid && res_ready) begin
                        bin       <= cap_mag;
                        pend_neg  <= cap_neg;
                        bcd       <= '0;
                        iter      <= '0;
                        state     <= CONV;
                        res_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                CONV: begin
                    bin  <= bin_next;
                    bcd  <= bcd_next;
                    iter <= iter + 1'b1;
                    // Display registers update only here, all at once, so the scan never
                    // shows a half-converted value.
                    if (iter == ITER_LAST) begin
                        disp_hund <= bcd_next[11:8];
                        disp_tens <= bcd_next[7:4];
                        disp_ones <= bcd_next[3:0];
                        disp_neg  <= pend_neg;
                        state     <= IDLE;
                        res_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= DIG_ONES;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == DIG_LAST) ? DIG_ONES : scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign digit_sel = DIGIT_SEL_MASK & (4'b0001 << scan_idx);

    logic [3:0] mux_bcd;
    logic       mux_blank;
    logic       sign_pos;
    logic [6:0] dec_seg;

    always_comb begin
        mux_bcd   = disp_ones;
        mux_blank = 1'b0;
        sign_pos  = 1'b0;
        case (scan_idx)
            DIG_ONES: begin
                mux_bcd   = disp_ones;
                mux_blank = 1'b0;
            end
            DIG_TENS: begin
                mux_bcd   = disp_tens;
                mux_blank = (disp_hund == 4'd0) && (disp_tens == 4'd0);
            end
            DIG_HUND: begin
                mux_bcd   = disp_hund;
                mux_blank = (disp_hund == 4'd0);
            end
            default: begin
                mux_blank = 1'b1;
                sign_pos  = 1'b1;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd   (mux_bcd),
        .blank (mux_blank),
        .seg   (dec_seg)
    );

    assign seg = sign_pos ? (disp_neg ? SEG_MINUS : SEG_BLANK) : dec_seg;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with REFRESH_DIV=4; signed checks need ALU_DISP_SIGNED_EN.
module tb_alu_result_display;

    logic       clk;
    logic       rst_n;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] digit_sel;

    int total = 0;
    int bad   = 0;

    alu_result_display #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a digit position, then counts how many samples it stays selected.
    task automatic measure_hold(input logic [3:0] sel, output int n, output logic [6:0] s);
        n = 0;
        s = 7'bx;
        for (int i = 0; i < 20 && digit_sel !== sel; i++) @(negedge clk);
        if (digit_sel === sel) begin
            s = seg;
            while (digit_sel === sel && n < 20) begin
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic read_pos(input int pos, output logic [6:0] s);
        logic [3:0] sel;
        sel = 4'b0001 << pos;
        s = 7'bx;
        for (int i = 0; i < 20 && digit_sel !== sel; i++) @(negedge clk);
        if (digit_sel === sel) s = seg;
    endtask

    // Called at a negedge while idle; returns at the negedge after the capture edge.
    task automatic push(input logic [7:0] v);
        res_valid = 1'b1;
        res_data  = v;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic wait_done(output int lo, output bit busy_bad);
        lo = 0;
        busy_bad = 1'b0;
        while (res_ready !== 1'b1 && lo < 30) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            lo++;
            @(negedge clk);
        end
    endtask

    function automatic logic [6:0] exp_of(input logic [3:0] sel, input logic [6:0] h,
                                          input logic [6:0] t, input logic [6:0] o);
        case (sel)
            4'b0001: return o;
            4'b0010: return t;
            4'b0100: return h;
            default: return 7'h00;
        endcase
    endfunction

    initial begin
        int n;
        int lo;
        int k;
        bit bb;
        bit sel3;
        logic [6:0] s;

        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_data  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_digit_sel", 32'(digit_sel), 32'h1);
        check("rst_seg", 32'(seg), 32'h3F);
        check("rst_ready", 32'(res_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);

        rst_n = 1'b1;
        measure_hold(4'b0010, n, s);
        check("scan_tens_hold", 32'(n), 32'd4);
        check("scan_tens_seg", 32'(s), 32'h00);
        measure_hold(4'b0100, n, s);
        check("scan_hund_hold", 32'(n), 32'd4);
        check("scan_hund_seg", 32'(s), 32'h00);
`ifndef ALU_DISP_SIGNED_EN
        sel3 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel3 |= digit_sel[3];
            @(negedge clk);
        end
        check("sel3_tied_low", 32'(sel3), 32'h0);

        push(8'd245);
        wait_done(lo, bb);
        check("245_ready_low_cycles", 32'(lo), 32'd8);
        check("245_busy_during_conv", 32'(bb), 32'h0);
        check("245_busy_after", 32'(busy), 32'h0);
        read_pos(0, s); check("245_ones", 32'(s), 32'h6D);
        read_pos(1, s); check("245_tens", 32'(s), 32'h66);
        read_pos(2, s); check("245_hund", 32'(s), 32'h5B);
`endif

        push(8'd7);
        wait_done(lo, bb);
        read_pos(0, s); check("7_ones", 32'(s), 32'h07);
        read_pos(1, s); check("7_tens", 32'(s), 32'h00);
        read_pos(2, s); check("7_hund", 32'(s), 32'h00);

        push(8'd105);
        wait_done(lo, bb);
        read_pos(1, s); check("105_tens", 32'(s), 32'h3F);
        read_pos(2, s); check("105_hund", 32'(s), 32'h06);
        read_pos(0, s); check("105_ones", 32'(s), 32'h6D);

        // 100 captured, then 9 held on the input throughout the conversion.
        res_valid = 1'b1;
        res_data  = 8'd100;
        @(negedge clk);
        res_data  = 8'd9;
        wait_done(lo, bb);
        check("100_ready_low_cycles", 32'(lo), 32'd8);
        check("100_visible", 32'(seg), 32'(exp_of(digit_sel, 7'h06, 7'h3F, 7'h3F)));
        k = 0;
        while (k < 30) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                res_valid = 1'b0;
                check("9_accepted_on_ready", 32'(res_ready), 32'h0);
            end
            if (res_ready === 1'b1) break;
            if (k <= 8) check("100_held_in_conv", 32'(seg), 32'(exp_of(digit_sel, 7'h06, 7'h3F, 7'h3F)));
        end
        check("9_done_after_cycles", 32'(k), 32'd9);
        read_pos(0, s); check("9_ones", 32'(s), 32'h6F);
        read_pos(1, s); check("9_tens", 32'(s), 32'h00);
        read_pos(2, s); check("9_hund", 32'(s), 32'h00);

        // Reset after four iterations of 200.
        push(8'd200);
        repeat (4) @(negedge clk);
        check("200_busy_before_abort", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(res_ready), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_seg", 32'(seg), 32'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        read_pos(1, s); check("abort_tens", 32'(s), 32'h00);
        read_pos(2, s); check("abort_hund", 32'(s), 32'h00);
        read_pos(0, s); check("abort_ones", 32'(s), 32'h3F);
        check("abort_ready_after", 32'(res_ready), 32'h1);

`ifdef ALU_DISP_SIGNED_EN
        push(8'hF0);
        wait_done(lo, bb);
        read_pos(3, s); check("f0_sign", 32'(s), 32'h40);
        read_pos(2, s); check("f0_hund", 32'(s), 32'h00);
        read_pos(1, s); check("f0_tens", 32'(s), 32'h06);
        read_pos(0, s); check("f0_ones", 32'(s), 32'h7D);

        push(8'h80);
        wait_done(lo, bb);
        read_pos(3, s); check("80_sign", 32'(s), 32'h40);
        read_pos(2, s); check("80_hund", 32'(s), 32'h06);
        read_pos(1, s); check("80_tens", 32'(s), 32'h5B);
        read_pos(0, s); check("80_ones", 32'(s), 32'h7F);

        push(8'h05);
        wait_done(lo, bb);
        read_pos(3, s); check("05_sign", 32'(s), 32'h00);
        read_pos(0, s); check("05_ones", 32'(s), 32'h6D);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
